imem_loader: RTL

Instruction-memory writer: accepts a byte stream with a valid/ready handshake, packs bytes big-endian into 32-bit words and writes them to consecutive word addresses of the instruction memory. It sits between an external byte source (UART/debug port) and the IM write port, and holds the PC while loading. Every image ends in a 32-bit XOR checksum trailer, which the block checks before it reports completion. It replaces file-based program preload for hardware bring-up.

---
 rtl/imem_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words,
// writes them to consecutive IM word addresses and verifies an XOR trailer.
module imem_loader #(
  parameter int MEM_DEPTH = 2048,
  parameter int CNT_W     = 12
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [31:0]      i_base_addr,
  input  logic [CNT_W-1:0] i_word_count,
  input  logic [7:0]       i_byte_in,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             o_im_we,
  output logic [31:0]      o_im_addr,
  output logic [31:0]      o_im_wdata,
  output logic             o_busy,
  output logic             o_cpu_hold,
  output logic             o_done,
  output logic [1:0]       o_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_FIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_bcnt;
  logic [23:0]      r_shift;
  logic [31:0]      r_addr;
  logic [31:0]      r_csum;
  logic [CNT_W-1:0] r_left;
  logic             r_im_we;
  logic [31:0]      r_im_addr;
  logic [31:0]      r_im_wdata;
  logic [1:0]       r_err;

  logic             w_go;
  logic             w_accept;
  logic             w_word_end;
  logic [31:0]      w_word;
  logic [32:0]      w_range_end;
  logic             w_range_err;

  // 33-bit sum so a huge base_addr cannot wrap past the bound
  assign w_range_end = {1'b0, i_base_addr} + 33'(i_word_count);
  assign w_range_err = w_range_end > 33'(MEM_DEPTH);
  assign w_go        = (r_state == S_IDLE) && i_start;
  assign w_accept    = o_byte_ready && i_byte_valid;
  assign w_word_end  = w_accept && (r_bcnt == 2'd3);
  assign w_word      = {r_shift, i_byte_in};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_range_err)              w_next = S_FIN;
          else if (i_word_count == '0)  w_next = S_CHECK;
          else                          w_next = S_LOAD;
        end
      end
      S_LOAD:  if (w_word_end && (r_left == CNT_W'(1))) w_next = S_CHECK;
      S_CHECK: if (w_word_end) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (r_state != S_IDLE);
    o_cpu_hold   = o_busy;
    o_byte_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
    o_done       = (r_state == S_FIN);
    o_im_we      = r_im_we;
    o_im_addr    = r_im_addr;
    o_im_wdata   = r_im_wdata;
    o_err        = r_err;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bcnt     <= 2'd0;
      r_im_we    <= 1'b0;
      r_im_addr  <= 32'd0;
      r_im_wdata <= 32'd0;
      r_err      <= 2'b00;
    end else begin
      r_im_we <= w_word_end && (r_state == S_LOAD);
      if (w_go) begin
        r_bcnt <= 2'd0;
        r_err  <= {w_range_err, 1'b0};
      end else begin
        if (w_accept) r_bcnt <= r_bcnt + 2'd1;
        if (w_word_end && (r_state == S_CHECK) && (w_word != r_csum)) r_err[0] <= 1'b1;
      end
      if (w_word_end && (r_state == S_LOAD)) begin
        r_im_addr  <= r_addr;
        r_im_wdata <= w_word;
      end
    end
  end

  // Datapath registers are always initialised by an accepted start before use
  always_ff @(posedge i_clock) begin
    if (w_go) begin
      r_addr <= i_base_addr;
      r_left <= i_word_count;
      r_csum <= 32'd0;
    end else if (w_accept) begin
      r_shift <= {r_shift[15:0], i_byte_in};
      if (w_word_end && (r_state == S_LOAD)) begin
        r_addr <= r_addr + 32'd1;
        r_left <= r_left - CNT_W'(1);
        r_csum <= r_csum ^ w_word;
      end
    end
  end

endmodule
